// File: rtl/hd_timing_gen.sv
// Beat/phase sequencer for the HD-CPU hardwired controller: one-hot beat W[3:1],
// phase strobes T1..T3, driven by SHORT/LONG/STOP requests and the START button.
module hd_timing_gen #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned START_SYNC = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       SHORT,
    input  logic       LONG,
    input  logic       STOP,
    output logic [3:1] W,
    output logic       T1,
    output logic       T2,
    output logic       T3,
    output logic       RUN,
    output logic       CYC_END
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] BEAT_W1 = 3'b001;
    localparam logic [2:0] BEAT_W2 = 3'b010;
    localparam logic [2:0] BEAT_W3 = 3'b100;
    localparam logic [2:0] PH_T1   = 3'b001;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              w_q, w_d;
    logic [2:0]              t_q, t_d;
    logic [2:0]              next_w_q, next_w_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [START_SYNC-1:0]   sync_q, sync_d;
    logic [START_SYNC-1:0]   vld_q, vld_d;
    logic                    low_seen_q, low_seen_d;
    logic                    rise_q, rise_d;

    logic                    tick;
    logic                    beat_end;
    logic [2:0]              next_beat;

    // A rise only counts after the synchronised START has been seen low since
    // reset; vld_q marks chain stages that hold post-reset samples.
    always_comb begin
        sync_d     = {sync_q[START_SYNC-2:0], START};
        vld_d      = {vld_q[START_SYNC-2:0], 1'b1};
        rise_d     = low_seen_q & sync_q[START_SYNC-1];
        low_seen_d = (low_seen_q | (vld_q[START_SYNC-1] & ~sync_q[START_SYNC-1])) & ~rise_d;
    end

    always_comb begin
        tick     = (div_q == DIV_W'(CLK_DIV - 1));
        beat_end = (state_q == S_RUN) && tick && t_q[2];
        unique case (w_q)
            BEAT_W1: next_beat = SHORT ? BEAT_W1 : BEAT_W2;
            BEAT_W2: next_beat = LONG  ? BEAT_W3 : BEAT_W1;
            default: next_beat = BEAT_W1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        t_d      = t_q;
        next_w_d = next_w_q;
        div_d    = div_q;
        unique case (state_q)
            S_IDLE: begin
                if (rise_q) begin
                    state_d = S_RUN;
                    w_d     = next_w_q;
                    t_d     = PH_T1;
                    div_d   = '0;
                end
            end
            S_RUN: begin
                if (!tick) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!t_q[2]) begin
                        t_d = {t_q[1:0], 1'b0};
                    end else if (STOP) begin
                        state_d  = S_IDLE;
                        next_w_d = next_beat;
                        w_d      = '0;
                        t_d      = '0;
                    end else begin
                        w_d = next_beat;
                        t_d = PH_T1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            t_q        <= '0;
            next_w_q   <= BEAT_W1;
            div_q      <= '0;
            sync_q     <= '0;
            vld_q      <= '0;
            low_seen_q <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            t_q        <= t_d;
            next_w_q   <= next_w_d;
            div_q      <= div_d;
            sync_q     <= sync_d;
            vld_q      <= vld_d;
            low_seen_q <= low_seen_d;
            rise_q     <= rise_d;
        end
    end

    assign W            = w_q;
    assign {T3, T2, T1} = t_q;
    assign RUN          = (state_q == S_RUN);
    // Marks the last clock of the beat whose successor is W1.
    assign CYC_END      = beat_end && (next_beat == BEAT_W1);

endmodule

// File: tb/tb_hd_timing_gen.sv
// Directed bench for hd_timing_gen: CLK_DIV=1 instance for sequencing, CLK_DIV=4 for timing.
module tb_hd_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic short_i = 1'b0;
    logic long_i = 1'b0;
    logic stop_i = 1'b0;

    logic [3:1] w_a, w_b;
    logic t1_a, t2_a, t3_a, run_a, cyc_a;
    logic t1_b, t2_b, t3_b, run_b, cyc_b;
    logic [2:0] t_a, t_b;

    int total = 0;
    int bad = 0;

    logic [2:0] exp_w [6] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010};
    logic [2:0] exp_t [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic       exp_c [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    assign t_a = {t3_a, t2_a, t1_a};
    assign t_b = {t3_b, t2_b, t1_b};

    always #5 clk = ~clk;

    hd_timing_gen #(.CLK_DIV(1), .START_SYNC(2)) dut_a (
        .CLK(clk), .RST(rst), .START(start), .SHORT(short_i), .LONG(long_i), .STOP(stop_i),
        .W(w_a), .T1(t1_a), .T2(t2_a), .T3(t3_a), .RUN(run_a), .CYC_END(cyc_a)
    );

    hd_timing_gen #(.CLK_DIV(4), .START_SYNC(2)) dut_b (
        .CLK(clk), .RST(rst), .START(start), .SHORT(short_i), .LONG(long_i), .STOP(stop_i),
        .W(w_b), .T1(t1_b), .T2(t2_b), .T3(t3_b), .RUN(run_b), .CYC_END(cyc_b)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        total++; if ({w_a, t_a, run_a, cyc_a} !== 8'h00) begin bad++; $display("FAIL reset_a: got %b want 00000000", {w_a, t_a, run_a, cyc_a}); end
        total++; if ({w_b, t_b, run_b, cyc_b} !== 8'h00) begin bad++; $display("FAIL reset_b: got %b want 00000000", {w_b, t_b, run_b, cyc_b}); end
        rst = 1'b0;
        step(5);
        total++; if (run_a !== 1'b0) begin bad++; $display("FAIL idle_after_reset: run got %b want 0", run_a); end
    endtask

    task automatic test_basic;
        start = 1'b1;
        step(3);
        total++; if (run_a !== 1'b0) begin bad++; $display("FAIL start_latency_early: run got %b want 0", run_a); end
        step(1);
        for (int i = 0; i < 7; i++) begin
            if (i == 0) start = 1'b0;
            total++; if (w_a !== exp_w[i % 6]) begin bad++; $display("FAIL basic_w[%0d]: got %b want %b", i, w_a, exp_w[i % 6]); end
            total++; if (t_a !== exp_t[i % 6]) begin bad++; $display("FAIL basic_t[%0d]: got %b want %b", i, t_a, exp_t[i % 6]); end
            total++; if (cyc_a !== exp_c[i % 6]) begin bad++; $display("FAIL basic_cyc[%0d]: got %b want %b", i, cyc_a, exp_c[i % 6]); end
            total++; if (run_a !== 1'b1) begin bad++; $display("FAIL basic_run[%0d]: got %b want 1", i, run_a); end
            if (i < 6) step(1);
        end
    endtask

    task automatic test_short;
        step(2);
        short_i = 1'b1;
        #1;
        total++; if (cyc_a !== 1'b1) begin bad++; $display("FAIL short_cyc: got %b want 1", cyc_a); end
        step(1);
        total++; if ({w_a, t_a} !== 6'b001_001) begin bad++; $display("FAIL short_next: got %b want 001001", {w_a, t_a}); end
        short_i = 1'b0;
    endtask

    task automatic test_long;
        short_i = 1'b1;
        long_i = 1'b1;
        step(2);
        total++; if (cyc_a !== 1'b1) begin bad++; $display("FAIL short_prio_cyc: got %b want 1", cyc_a); end
        step(1);
        total++; if ({w_a, t_a} !== 6'b001_001) begin bad++; $display("FAIL short_prio_next: got %b want 001001", {w_a, t_a}); end
        short_i = 1'b0;
        step(2);
        total++; if (cyc_a !== 1'b0) begin bad++; $display("FAIL long_w1_cyc: got %b want 0", cyc_a); end
        step(1);
        total++; if ({w_a, t_a} !== 6'b010_001) begin bad++; $display("FAIL long_w2: got %b want 010001", {w_a, t_a}); end
        step(2);
        total++; if (cyc_a !== 1'b0) begin bad++; $display("FAIL long_w2_cyc: got %b want 0", cyc_a); end
        step(1);
        total++; if ({w_a, t_a} !== 6'b100_001) begin bad++; $display("FAIL long_w3: got %b want 100001", {w_a, t_a}); end
        step(2);
        total++; if ({w_a, t_a, cyc_a} !== 7'b100_100_1) begin bad++; $display("FAIL long_w3_end: got %b want 1001001", {w_a, t_a, cyc_a}); end
        long_i = 1'b0;
        step(1);
        total++; if ({w_a, t_a} !== 6'b001_001) begin bad++; $display("FAIL long_back_w1: got %b want 001001", {w_a, t_a}); end
    endtask

    task automatic test_stop;
        logic prev_run;
        int rises;
        step(2);
        stop_i = 1'b1;
        #1;
        total++; if (cyc_a !== 1'b0) begin bad++; $display("FAIL stop_w1_cyc: got %b want 0", cyc_a); end
        step(1);
        total++; if ({w_a, t_a, run_a, cyc_a} !== 8'h00) begin bad++; $display("FAIL stop_idle: got %b want 00000000", {w_a, t_a, run_a, cyc_a}); end
        stop_i = 1'b0;
        prev_run = run_a;
        rises = 0;
        start = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step(1);
            if (run_a && !prev_run) rises++;
            prev_run = run_a;
            if (k < 4) begin
                total++; if (run_a !== 1'b0) begin bad++; $display("FAIL resume_early[%0d]: run got %b want 0", k, run_a); end
            end else begin
                total++; if ({w_a, t_a} !== {exp_w[(k - 1) % 6], exp_t[(k - 1) % 6]}) begin
                    bad++; $display("FAIL resume_seq[%0d]: got %b want %b", k, {w_a, t_a}, {exp_w[(k - 1) % 6], exp_t[(k - 1) % 6]});
                end
                total++; if (cyc_a !== exp_c[(k - 1) % 6]) begin bad++; $display("FAIL resume_cyc[%0d]: got %b want %b", k, cyc_a, exp_c[(k - 1) % 6]); end
            end
            if (k == 21) start = 1'b0;
            if (k == 25) start = 1'b1;
        end
        total++; if (rises !== 1) begin bad++; $display("FAIL resume_count: got %0d want 1", rises); end
        start = 1'b0;
    endtask

    task automatic test_mid_reset;
        int p;
        logic [2:0] ew, et;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);
        total++; if ({w_b, t_b, run_b} !== 7'h00) begin bad++; $display("FAIL div4_idle: got %b want 0000000", {w_b, t_b, run_b}); end
        start = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            step(1);
            if (k == 2) start = 1'b0;
            if (k >= 4) begin
                p = (k - 4) / 4;
                ew = (p < 3) ? 3'b001 : 3'b010;
                et = 3'b001 << (p % 3);
                total++; if ({w_b, t_b, cyc_b} !== {ew, et, 1'b0}) begin
                    bad++; $display("FAIL div4_seq[%0d]: got %b want %b", k, {w_b, t_b, cyc_b}, {ew, et, 1'b0});
                end
            end
        end
        rst = 1'b1;
        step(1);
        total++; if ({w_b, t_b, run_b, cyc_b} !== 8'h00) begin bad++; $display("FAIL div4_mid_reset: got %b want 00000000", {w_b, t_b, run_b, cyc_b}); end
        rst = 1'b0;
        step(5);
        start = 1'b1;
        step(4);
        total++; if ({w_b, t_b, run_b} !== 7'b001_001_1) begin bad++; $display("FAIL div4_restart: got %b want 0010011", {w_b, t_b, run_b}); end
        total++; if ({w_a, t_a, run_a} !== 7'b001_001_1) begin bad++; $display("FAIL div1_restart: got %b want 0010011", {w_a, t_a, run_a}); end
        start = 1'b0;
    endtask

    task automatic test_start_held;
        start = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(10);
        total++; if (run_a !== 1'b0) begin bad++; $display("FAIL held_a: run got %b want 0", run_a); end
        total++; if (run_b !== 1'b0) begin bad++; $display("FAIL held_b: run got %b want 0", run_b); end
        start = 1'b0;
        step(4);
        start = 1'b1;
        step(3);
        total++; if (run_a !== 1'b0) begin bad++; $display("FAIL held_edge_early: run got %b want 0", run_a); end
        step(1);
        total++; if ({w_a, t_a, run_a} !== 7'b001_001_1) begin bad++; $display("FAIL held_edge_start: got %b want 0010011", {w_a, t_a, run_a}); end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_long();
        test_stop();
        test_mid_reset();
        test_start_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
